ram_arbiter: RTL and testbench

- Shares the single-port RAM (address register latched by MI, write strobe RI, combinational read of ram[mar]) between two requesters.
- Port 0 is the CPU control path. Port 1 is a debug/loader port that preloads programs and inspects memory while the CPU runs.
- Converts each granted request into the two-step RAM protocol: ADDR (load the address register), then DATA (write, or capture the read).
- Sits between the requesters and the memory module; drives that module's MI, RI and write bus.

---
 rtl/ram_arbiter_pkg.sv | 26 ++
 rtl/ram_arbiter_if.sv | 64 ++++++
 rtl/ram_arbiter_rr_arb2.sv | 30 +++
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the two-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Requester indices double as bit positions in the req/gnt vectors
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Requester handshakes and RAM strobe bus of the arbiter.
//               Lock inputs exist only when RAM_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
    parameter int WIDTH = 8
) ();

    logic             cpu_req;
    logic             cpu_we;
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic             cpu_gnt;
    logic             cpu_done;

    logic             dbg_req;
    logic             dbg_we;
    logic [WIDTH-1:0] dbg_addr;
    logic [WIDTH-1:0] dbg_wdata;
    logic             dbg_gnt;
    logic             dbg_done;

`ifdef RAM_ARB_LOCK_EN
    logic             cpu_lock;
    logic             dbg_lock;
`endif

    logic [WIDTH-1:0] rdata;
    logic             busy;

    logic             mem_mi;
    logic             mem_ri;
    logic [WIDTH-1:0] mem_wbus;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
`ifdef RAM_ARB_LOCK_EN
        input  cpu_lock, dbg_lock,
`endif
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_done, dbg_gnt, dbg_done,
        output rdata, busy,
        output mem_mi, mem_ri, mem_wbus
    );

    modport master (
`ifdef RAM_ARB_LOCK_EN
        output cpu_lock, dbg_lock,
`endif
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_done, dbg_gnt, dbg_done,
        input  rdata, busy,
        input  mem_mi, mem_ri, mem_wbus
    );

endinterface
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin pick with eligibility mask.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic [1:0] i_req,
    input  wire logic       i_last_grant,
    input  wire logic [1:0] i_lock_mask,
    output logic      [1:0] o_gnt
);

    logic [1:0] w_elig;

    assign w_elig = i_req & i_lock_mask;

    always_comb begin
        o_gnt = 2'b00;
        case (w_elig)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // On a tie the port that did not win last time goes first
            2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares a single-port RAM between CPU and debug requesters,
//               sequencing each grant as ADDR (MI) then DATA (RI / capture).
//               Optional owner lock enabled by RAM_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic      clk,
    input  wire logic      reset,
    ram_arbiter_if.slave   bus
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;

    logic             r_owner;
    logic             r_we;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic             r_last_grant;
    logic             r_cpu_gnt;
    logic             r_dbg_gnt;
    logic             r_cpu_done;
    logic             r_dbg_done;

    logic [1:0]       w_req;
    logic [1:0]       w_lock_mask;
    logic [1:0]       w_gnt;
    logic             w_locked;
    logic             w_grant_any;
    logic             w_win;

    logic             w_mem_mi;
    logic             w_mem_ri;
    logic [WIDTH-1:0] w_mem_wbus;

    assign w_req = {bus.dbg_req, bus.cpu_req};

`ifdef RAM_ARB_LOCK_EN
    logic r_lock_active;
    logic w_done_now;
    logic w_owner_lock;

    // The lock is judged live in the done cycle, then held until the next done
    assign w_done_now   = r_cpu_done | r_dbg_done;
    assign w_owner_lock = r_owner ? bus.dbg_lock : bus.cpu_lock;
    assign w_locked     = w_done_now ? w_owner_lock : r_lock_active;
    assign w_lock_mask  = w_locked ? req_onehot(r_owner) : 2'b11;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_active <= 1'b0;
        end else if (w_done_now) begin
            r_lock_active <= w_owner_lock;
        end
    end
`else
    assign w_locked    = 1'b0;
    assign w_lock_mask = 2'b11;
`endif

    rr_arb2 u_rr_arb2 (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .i_lock_mask  (w_lock_mask),
        .o_gnt        (w_gnt)
    );

    assign w_grant_any = (r_state == ARB_IDLE) && (w_gnt != 2'b00);
    assign w_win       = w_gnt[REQ_DBG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_mi     = 1'b0;
        w_mem_ri     = 1'b0;
        w_mem_wbus   = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_any) begin
                    w_state_next = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                w_mem_mi     = 1'b1;
                w_mem_wbus   = r_addr;
                w_state_next = ARB_DATA;
            end
            ARB_DATA: begin
                if (r_we) begin
                    w_mem_ri   = 1'b1;
                    w_mem_wbus = r_wdata;
                end
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= REQ_CPU;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_last_grant <= REQ_DBG;
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_dbg_done   <= 1'b0;
        end else begin
            r_cpu_gnt  <= w_grant_any & w_gnt[REQ_CPU];
            r_dbg_gnt  <= w_grant_any & w_gnt[REQ_DBG];
            r_cpu_done <= (r_state == ARB_DATA) && (r_owner == REQ_CPU);
            r_dbg_done <= (r_state == ARB_DATA) && (r_owner == REQ_DBG);

            if (w_grant_any) begin
                r_owner <= w_win;
                r_we    <= w_win ? bus.dbg_we    : bus.cpu_we;
                r_addr  <= w_win ? bus.dbg_addr  : bus.cpu_addr;
                r_wdata <= w_win ? bus.dbg_wdata : bus.cpu_wdata;
                // Locked re-grants must not disturb round-robin fairness
                if (!w_locked) begin
                    r_last_grant <= w_win;
                end
            end

            if ((r_state == ARB_DATA) && !r_we) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_gnt  = r_cpu_gnt;
    assign bus.dbg_gnt  = r_dbg_gnt;
    assign bus.cpu_done = r_cpu_done;
    assign bus.dbg_done = r_dbg_done;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = (r_state != ARB_IDLE);
    assign bus.mem_mi   = w_mem_mi;
    assign bus.mem_ri   = w_mem_ri;
    assign bus.mem_wbus = w_mem_wbus;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed bench for ram_arbiter with a behavioural RAM model.
//               Lock scenario runs only when RAM_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    logic clk;
    logic reset;
    logic mem_clr;
    int   n_checks;
    int   n_errors;

    ram_arbiter_if #(.WIDTH(8)) bus ();

    ram_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: MI loads the address register, RI writes, read is combinational
    logic [7:0] ram [256];
    logic [7:0] mar;

    always @(posedge clk) begin
        if (mem_clr) begin
            mar <= 8'h00;
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else begin
            if (bus.mem_mi) mar <= bus.mem_wbus;
            if (bus.mem_ri) ram[mar] <= bus.mem_wbus;
        end
    end

    assign bus.mem_rdata = ram[mar];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        mem_clr       = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 8'h00;
        bus.cpu_wdata = 8'h00;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = 8'h00;
        bus.dbg_wdata = 8'h00;
`ifdef RAM_ARB_LOCK_EN
        bus.cpu_lock  = 1'b0;
        bus.dbg_lock  = 1'b0;
`endif
        tick();
        tick();

        // Reset state
        check1("rst_busy",     bus.busy,     1'b0);
        check1("rst_cpu_gnt",  bus.cpu_gnt,  1'b0);
        check1("rst_dbg_done", bus.dbg_done, 1'b0);
        check1("rst_mem_mi",   bus.mem_mi,   1'b0);
        check1("rst_mem_ri",   bus.mem_ri,   1'b0);
        check8("rst_mem_wbus", bus.mem_wbus, 8'h00);
        check8("rst_rdata",    bus.rdata,    8'h00);
        reset   = 1'b0;
        mem_clr = 1'b0;
        tick();

        // CPU write 5A -> 20, then read back
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h20; bus.cpu_wdata = 8'h5A;
        tick();
        check1("w1_gnt",   bus.cpu_gnt,  1'b1);
        check1("w1_mi",    bus.mem_mi,   1'b1);
        check1("w1_ri_a",  bus.mem_ri,   1'b0);
        check8("w1_wbusa", bus.mem_wbus, 8'h20);
        check1("w1_busy",  bus.busy,     1'b1);
        bus.cpu_req = 1'b0;
        tick();
        check1("w1_ri",    bus.mem_ri,   1'b1);
        check1("w1_mi_d",  bus.mem_mi,   1'b0);
        check8("w1_wbusd", bus.mem_wbus, 8'h5A);
        check1("w1_ngnt",  bus.cpu_gnt,  1'b0);
        tick();
        check1("w1_done",  bus.cpu_done, 1'b1);
        check1("w1_idle",  bus.busy,     1'b0);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h20;
        tick();
        check1("r1_gnt",   bus.cpu_gnt,  1'b1);
        check1("r1_ndone", bus.cpu_done, 1'b0);
        bus.cpu_req = 1'b0;
        tick();
        check1("r1_ri",    bus.mem_ri,   1'b0);
        check8("r1_wbusd", bus.mem_wbus, 8'h00);
        tick();
        check1("r1_done",  bus.cpu_done, 1'b1);
        check8("r1_rdata", bus.rdata,    8'h5A);
        tick();
        check1("r1_done_pulse", bus.cpu_done, 1'b0);

        // Sustained contention after reset: CPU, DBG, CPU, DBG
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h20;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h21;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check1($sformatf("rr_cpu_gnt_c%0d", k), bus.cpu_gnt, (k == 1) || (k == 7));
            check1($sformatf("rr_dbg_gnt_c%0d", k), bus.dbg_gnt, (k == 4) || (k == 10));
            check1($sformatf("rr_excl_c%0d", k), bus.cpu_gnt & bus.dbg_gnt, 1'b0);
            check1($sformatf("rr_cpu_done_c%0d", k), bus.cpu_done, (k == 3) || (k == 9));
            check1($sformatf("rr_dbg_done_c%0d", k), bus.dbg_done, (k == 6) || (k == 12));
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        tick();
        check1("rr_quiet", bus.busy, 1'b0);

        // DBG write 11 -> 30, then CPU read 30
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h30; bus.dbg_wdata = 8'h11;
        tick();
        check1("dw_gnt", bus.dbg_gnt, 1'b1);
        bus.dbg_req = 1'b0;
        tick();
        check1("dw_ri",   bus.mem_ri,   1'b1);
        check8("dw_wbus", bus.mem_wbus, 8'h11);
        tick();
        check1("dw_done",  bus.dbg_done, 1'b1);
        check1("dw_ncpu",  bus.cpu_done, 1'b0);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h30;
        tick();
        check1("cr_gnt",        bus.cpu_gnt,  1'b1);
        check1("dw_done_pulse", bus.dbg_done, 1'b0);
        bus.cpu_req = 1'b0;
        tick();
        tick();
        check1("cr_done",  bus.cpu_done, 1'b1);
        check8("cr_rdata", bus.rdata,    8'h11);
        tick();
        check1("cr_done_pulse", bus.cpu_done, 1'b0);

        // Reset during the DATA cycle of a DBG write
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h40; bus.dbg_wdata = 8'h77;
        tick();
        check1("ab_gnt", bus.dbg_gnt, 1'b1);
        bus.dbg_req = 1'b0;
        tick();
        check1("ab_ri_before", bus.mem_ri, 1'b1);
        reset = 1'b1;
        #1;
        check1("ab_busy",  bus.busy,     1'b0);
        check1("ab_ri",    bus.mem_ri,   1'b0);
        check1("ab_mi",    bus.mem_mi,   1'b0);
        check8("ab_wbus",  bus.mem_wbus, 8'h00);
        check8("ab_rdata", bus.rdata,    8'h00);
        tick();
        check1("ab_no_done_rst", bus.dbg_done, 1'b0);
        reset = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h20;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h30;
        tick();
        check1("ab_no_done", bus.dbg_done, 1'b0);
        check1("ab_cpu_first", bus.cpu_gnt, 1'b1);
        check1("ab_dbg_wait",  bus.dbg_gnt, 1'b0);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        tick();
        tick();
        check1("ab_cpu_done", bus.cpu_done, 1'b1);
        tick();

        // Idle bus
        for (int k = 0; k < 10; k++) begin
            tick();
            check1($sformatf("idle_busy_%0d", k), bus.busy, 1'b0);
            check1($sformatf("idle_strb_%0d", k), bus.mem_mi | bus.mem_ri, 1'b0);
            check8($sformatf("idle_wbus_%0d", k), bus.mem_wbus, 8'h00);
        end

`ifdef RAM_ARB_LOCK_EN
        // last_grant is CPU here, so an unlocked tie would go to DBG
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h20; bus.cpu_lock = 1'b1;
        tick();
        check1("lk_gnt1", bus.cpu_gnt, 1'b1);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h30;
        tick();
        tick();
        check1("lk_done1", bus.cpu_done, 1'b1);
        check8("lk_rdata1", bus.rdata, 8'h5A);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h50; bus.cpu_wdata = 8'h99;
        tick();
        check1("lk_gnt2_cpu", bus.cpu_gnt, 1'b1);
        check1("lk_gnt2_dbg", bus.dbg_gnt, 1'b0);
        bus.cpu_req  = 1'b0;
        bus.cpu_lock = 1'b0;
        tick();
        check8("lk_wbus2", bus.mem_wbus, 8'h99);
        tick();
        check1("lk_done2",     bus.cpu_done, 1'b1);
        check1("lk_dbg_block", bus.dbg_gnt,  1'b0);
        tick();
        check1("lk_dbg_gnt", bus.dbg_gnt, 1'b1);
        bus.dbg_req = 1'b0;
        tick();
        tick();
        check1("lk_dbg_done",  bus.dbg_done, 1'b1);
        check8("lk_dbg_rdata", bus.rdata,    8'h11);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
